// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vm_pkg
// Brief    : Shared types and constants for the vending-machine dispense and
//            payout sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package vm_pkg;

    // Top-level sequencer states; the payout phase is a single wait state
    // while the hopper pulser runs its own high/low timing.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_PAYOUT   = 2'd2
    } main_state_e;

    // Hopper pulser states (high and low phase of each coin).
    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_HI   = 2'd1,
        PS_LO   = 2'd2
    } pulse_state_e;

    // Change codes delivered by the coin FSM.
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    // Product price expressed in 5 rs coins.
    localparam logic [2:0] PRICE_COINS = 3'd3;

    // Default parameter values.
    localparam int DEF_NUM_SLOTS     = 4;
    localparam int DEF_STOCK_W       = 4;
    localparam int DEF_INIT_STOCK    = 8;
    localparam int DEF_MOTOR_TIMEOUT = 255;
    localparam int DEF_PULSE_LEN     = 4;

endpackage : vm_pkg
`default_nettype wire

// File: rtl/vm_dispense_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface: vm_dispense_ctrl_if
// Brief    : Request, motor and hopper signals between the coin FSM side and
//            the dispense sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface vm_dispense_ctrl_if #(
    parameter int NUM_SLOTS = 4
);
    logic                 vend_req;
    logic [1:0]           change_req;
    logic [1:0]           sel;
    logic                 restock;
    logic                 motor_done;
    logic                 busy;
    logic [NUM_SLOTS-1:0] motor_en;
    logic                 hopper_pulse;
    logic [NUM_SLOTS-1:0] sold_out;
    logic                 fault;

    // Upstream side: issues requests and reports the drop sensor.
    modport master (
        output vend_req, change_req, sel, restock, motor_done,
        input  busy, motor_en, hopper_pulse, sold_out, fault
    );

    // Sequencer side.
    modport slave (
        input  vend_req, change_req, sel, restock, motor_done,
        output busy, motor_en, hopper_pulse, sold_out, fault
    );
endinterface : vm_dispense_ctrl_if
`default_nettype wire

// File: rtl/vm_hopper_pulser.sv
`default_nettype none
// ============================================================================
// Module   : vm_hopper_pulser
// Brief    : Emits one PULSE_LEN-high / PULSE_LEN-low pulse per 5 rs coin and
//            flags done in the final low cycle.
// Revision : 1.0 - initial release
// ============================================================================
module vm_hopper_pulser
    import vm_pkg::*;
#(
    parameter int PULSE_LEN = DEF_PULSE_LEN
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_start,
    input  wire logic [2:0] i_coins,
    output logic            o_pulse,
    output logic            o_done
);
    localparam int c_CNT_W = $clog2(PULSE_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PULSE_LEN - 1);

    pulse_state_e       r_state, w_next_state;
    logic [c_CNT_W-1:0] r_cnt, w_next_cnt;
    logic [2:0]         r_coins, w_next_coins;

    // State, phase counter and remaining-coin register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PS_IDLE;
            r_cnt   <= '0;
            r_coins <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_coins <= w_next_coins;
        end
    end

    // Phase sequencing: a coin is counted off at the end of its high phase.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_coins = r_coins;
        o_done       = 1'b0;
        case (r_state)
            PS_IDLE: begin
                if (i_start && (i_coins != 3'd0)) begin
                    w_next_state = PS_HI;
                    w_next_cnt   = '0;
                    w_next_coins = i_coins;
                end
            end
            PS_HI: begin
                if (r_cnt == c_LAST) begin
                    w_next_state = PS_LO;
                    w_next_cnt   = '0;
                    w_next_coins = (r_coins != 3'd0) ? r_coins - 3'd1 : 3'd0;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            PS_LO: begin
                if (r_cnt == c_LAST) begin
                    w_next_cnt = '0;
                    if (r_coins != 3'd0) begin
                        w_next_state = PS_HI;
                    end else begin
                        w_next_state = PS_IDLE;
                        o_done       = 1'b1;
                    end
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            default: w_next_state = PS_IDLE;
        endcase
    end

    assign o_pulse = (r_state == PS_HI);

endmodule : vm_hopper_pulser
`default_nettype wire

// File: rtl/vm_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vm_dispense_ctrl
// Brief    : Dispense and payout sequencer: slot stock inventory, motor drive
//            with timeout, change/refund payout via the hopper pulser.
// Revision : 1.0 - initial release
// ============================================================================
module vm_dispense_ctrl
    import vm_pkg::*;
#(
    parameter int NUM_SLOTS     = DEF_NUM_SLOTS,
    parameter int STOCK_W       = DEF_STOCK_W,
    parameter int INIT_STOCK    = DEF_INIT_STOCK,
    parameter int MOTOR_TIMEOUT = DEF_MOTOR_TIMEOUT,
    parameter int PULSE_LEN     = DEF_PULSE_LEN
) (
    input  wire logic         clk,
    input  wire logic         rst,
    vm_dispense_ctrl_if.slave bus
);
    localparam int c_TMO_W = $clog2(MOTOR_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(MOTOR_TIMEOUT - 1);
    localparam logic [STOCK_W-1:0] c_INIT     = STOCK_W'(INIT_STOCK);

    main_state_e          r_state, w_next_state;
    logic [2:0]           r_coins, w_next_coins, w_chg_coins, w_load;
    logic [1:0]           r_sel;
    logic [c_TMO_W-1:0]   r_tmo;
    logic                 r_fault;
    logic [STOCK_W-1:0]   r_stock [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_empty;
    logic                 w_event, w_sel_ok, w_sel_empty, w_vend_ok;
    logic                 w_start, w_dispense_ok, w_timeout, w_pay_done, w_pulse;

    // Per-slot sold-out flags and one-hot motor drive.
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        assign w_empty[i]      = (r_stock[i] == '0);
        assign bus.motor_en[i] = (r_state == ST_DISPENSE) && (r_sel == 2'(i));
    end

    // Request decode: change code to coin count, selected-slot emptiness.
    always_comb begin
        w_sel_empty = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.sel == 2'(i)) w_sel_empty = w_empty[i];
        end
        case (bus.change_req)
            COIN_5:  w_chg_coins = 3'd1;
            COIN_10: w_chg_coins = 3'd2;
            default: w_chg_coins = 3'd0;
        endcase
    end

    assign w_event   = bus.vend_req || (bus.change_req == COIN_5) || (bus.change_req == COIN_10);
    assign w_sel_ok  = (int'(bus.sel) < NUM_SLOTS);
    assign w_vend_ok = bus.vend_req && w_sel_ok && !w_sel_empty && !r_fault;

    // Next-state logic; coins owed are handed to the pulser as payout starts.
    always_comb begin
        w_next_state  = r_state;
        w_next_coins  = r_coins;
        w_load        = 3'd0;
        w_start       = 1'b0;
        w_dispense_ok = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vend_ok) begin
                    w_next_state = ST_DISPENSE;
                    w_next_coins = w_chg_coins;
                end else if (w_event) begin
                    w_load       = bus.vend_req ? w_chg_coins + PRICE_COINS : w_chg_coins;
                    w_start      = 1'b1;
                    w_next_coins = 3'd0;
                    w_next_state = ST_PAYOUT;
                end
            end
            ST_DISPENSE: begin
                if (bus.motor_done) begin
                    w_dispense_ok = 1'b1;
                    w_next_coins  = 3'd0;
                    if (r_coins != 3'd0) begin
                        w_load       = r_coins;
                        w_start      = 1'b1;
                        w_next_state = ST_PAYOUT;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else if (r_tmo == c_TMO_LAST) begin
                    w_timeout    = 1'b1;
                    w_load       = r_coins + PRICE_COINS;
                    w_start      = 1'b1;
                    w_next_coins = 3'd0;
                    w_next_state = ST_PAYOUT;
                end
            end
            ST_PAYOUT: begin
                if (w_pay_done) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Sequencer registers: state, latched slot, motor timer, sticky fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_coins <= 3'd0;
            r_sel   <= 2'd0;
            r_tmo   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_coins <= w_next_coins;
            if (w_vend_ok && (r_state == ST_IDLE)) r_sel <= bus.sel;
            r_tmo   <= (r_state == ST_DISPENSE) ? r_tmo + 1'b1 : '0;
            if (w_timeout) r_fault <= 1'b1;
        end
    end

    // Stock counters: decrement on successful drop, reload only on a free IDLE cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rst) begin
                r_stock[i] <= c_INIT;
            end else if (w_dispense_ok && (r_sel == 2'(i)) && !w_empty[i]) begin
                r_stock[i] <= r_stock[i] - 1'b1;
            end else if ((r_state == ST_IDLE) && !w_event && bus.restock) begin
                r_stock[i] <= c_INIT;
            end
        end
    end

    vm_hopper_pulser #(
        .PULSE_LEN (PULSE_LEN)
    ) u_pulser (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_coins (w_load),
        .o_pulse (w_pulse),
        .o_done  (w_pay_done)
    );

    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.hopper_pulse = w_pulse;
    assign bus.sold_out     = w_empty;
    assign bus.fault        = r_fault;

endmodule : vm_dispense_ctrl
`default_nettype wire

// File: tb/tb_vm_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vm_dispense_ctrl
// Brief    : Self-checking bench for vm_dispense_ctrl: vector table, corner
//            sequences and randomized transactions against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vm_dispense_ctrl;
    localparam int NS    = 4;
    localparam int TMO   = 255;
    localparam int PL    = 4;
    localparam int INIT  = 8;

    logic clk;
    logic rst;

    vm_dispense_ctrl_if #(.NUM_SLOTS(NS)) bus ();

    vm_dispense_ctrl #(
        .NUM_SLOTS     (NS),
        .STOCK_W       (4),
        .INIT_STOCK    (INIT),
        .MOTOR_TIMEOUT (TMO),
        .PULSE_LEN     (PL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         vend;
        logic [1:0] sel;
        logic [1:0] chg;
        int         k;
        int         e_motor;
        logic [3:0] e_mask;
        int         e_pulses;
        int         e_busy;
        logic [3:0] e_sold;
        bit         e_fault;
    } vec_t;

    vec_t vecs [7];
    vec_t none_row;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: stock per slot and sticky fault.
    int m_stock [NS];
    bit m_fault;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] model_sold();
        logic [3:0] r;
        for (int i = 0; i < NS; i++) r[i] = (m_stock[i] == 0);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_stock[i] = INIT;
        m_fault = 1'b0;
    endtask

    // Transaction-level rules: price is three coins, refunds on any failed vend.
    task automatic model_txn(input bit vend, input logic [1:0] s, input logic [1:0] chg, input int k,
                             output int e_m, output logic [3:0] e_mask, output int e_p, output int e_busy);
        int coins;
        coins  = (chg == 2'b01) ? 1 : (chg == 2'b10) ? 2 : 0;
        e_m    = 0;
        e_mask = 4'b0;
        if (vend) begin
            if (int'(s) < NS && m_stock[s] > 0 && !m_fault) begin
                e_mask = 4'b0001 << s;
                if (k <= TMO) begin
                    e_m = k;
                    m_stock[s] = m_stock[s] - 1;
                end else begin
                    e_m     = TMO;
                    m_fault = 1'b1;
                    coins   = coins + 3;
                end
            end else begin
                coins = coins + 3;
            end
        end
        e_p    = coins;
        e_busy = e_m + 2 * PL * coins;
    endtask

    // Issue one request, then observe motor, hopper and busy until idle.
    // motor_done is raised so it is sampled in the k-th motor cycle.
    // inj != 0 pulses a vend request at that busy cycle (should be dropped).
    task automatic do_txn(input bit vend, input logic [1:0] s, input logic [1:0] chg, input int k,
                          input int inj, output int g_m, output logic [3:0] g_mask, output int g_p,
                          output bit g_shape, output int g_busy, output bit g_to);
        int  hi_len, lo_len;
        bit  prev;
        bus.vend_req   = vend;
        bus.sel        = s;
        bus.change_req = chg;
        tick();
        bus.vend_req   = 1'b0;
        bus.change_req = 2'b00;
        g_m = 0; g_mask = 4'b0; g_p = 0; g_shape = 1'b1; g_busy = 0; g_to = 1'b0;
        hi_len = 0; lo_len = 0; prev = 1'b0;
        while (bus.busy) begin
            if (g_busy > 3000) begin
                g_to = 1'b1;
                break;
            end
            g_busy++;
            if (bus.motor_en != 0) begin
                g_m++;
                g_mask = g_mask | bus.motor_en;
                if (g_m == k) bus.motor_done = 1'b1;
            end else begin
                bus.motor_done = 1'b0;
            end
            if (bus.hopper_pulse) begin
                if (!prev) begin
                    g_p++;
                    if (g_p > 1 && lo_len != PL) g_shape = 1'b0;
                    hi_len = 0;
                end
                hi_len++;
            end else begin
                if (prev) begin
                    if (hi_len != PL) g_shape = 1'b0;
                    lo_len = 0;
                end
                lo_len++;
            end
            prev = bus.hopper_pulse;
            if (inj != 0 && g_busy == inj) begin
                bus.vend_req = 1'b1;
                bus.sel      = 2'd2;
            end else begin
                bus.vend_req = 1'b0;
            end
            tick();
        end
        bus.vend_req   = 1'b0;
        bus.motor_done = 1'b0;
        if (g_p > 0 && (prev || lo_len != PL)) g_shape = 1'b0;
    endtask

    task automatic run_txn(input string name, input bit vend, input logic [1:0] s, input logic [1:0] chg,
                           input int k, input int inj, input bit tbl, input vec_t row);
        int e_m, e_p, e_busy, g_m, g_p, g_busy;
        logic [3:0] e_mask, e_sold, g_mask;
        bit e_fault, g_shape, g_to;
        model_txn(vend, s, chg, k, e_m, e_mask, e_p, e_busy);
        e_sold  = model_sold();
        e_fault = m_fault;
        if (tbl) begin
            e_m = row.e_motor; e_mask = row.e_mask; e_p = row.e_pulses;
            e_busy = row.e_busy; e_sold = row.e_sold; e_fault = row.e_fault;
        end
        do_txn(vend, s, chg, k, inj, g_m, g_mask, g_p, g_shape, g_busy, g_to);
        check({name, " busy_bound"}, g_to, 0);
        check({name, " motor_cycles"}, g_m, e_m);
        check({name, " motor_en"}, g_mask, e_mask);
        check({name, " pulses"}, g_p, e_p);
        check({name, " pulse_shape"}, g_shape, 1);
        check({name, " busy_cycles"}, g_busy, e_busy);
        check({name, " sold_out"}, bus.sold_out, e_sold);
        check({name, " fault"}, bus.fault, e_fault);
    endtask

    task automatic do_restock();
        bus.restock = 1'b1;
        tick();
        bus.restock = 1'b0;
        for (int i = 0; i < NS; i++) m_stock[i] = INIT;
        check("restock sold_out", bus.sold_out, 4'b0000);
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r_v, r_k, r_n;
        logic [1:0] r_s, r_c;

        // Table: {vend, sel, chg, k, motor, mask, pulses, busy, sold, fault}
        vecs[0] = '{1'b1, 2'd2, 2'd0, 5,   5,   4'b0100, 0, 5,   4'b0000, 1'b0};
        vecs[1] = '{1'b1, 2'd1, 2'd2, 3,   3,   4'b0010, 2, 19,  4'b0000, 1'b0};
        vecs[2] = '{1'b0, 2'd0, 2'd1, 0,   0,   4'b0000, 1, 8,   4'b0000, 1'b0};
        vecs[3] = '{1'b0, 2'd0, 2'd3, 0,   0,   4'b0000, 0, 0,   4'b0000, 1'b0};
        vecs[4] = '{1'b1, 2'd0, 2'd1, 1,   1,   4'b0001, 1, 9,   4'b0000, 1'b0};
        vecs[5] = '{1'b1, 2'd3, 2'd0, 255, 255, 4'b1000, 0, 255, 4'b0000, 1'b0};
        vecs[6] = '{1'b1, 2'd3, 2'd3, 1,   1,   4'b1000, 0, 1,   4'b0000, 1'b0};
        none_row = vecs[0];

        rst = 1'b1;
        bus.vend_req = 1'b0; bus.change_req = 2'b00; bus.sel = 2'd0;
        bus.restock = 1'b0; bus.motor_done = 1'b0;
        model_reset();
        repeat (3) tick();
        check("reset busy", bus.busy, 0);
        check("reset motor_en", bus.motor_en, 4'b0000);
        check("reset hopper", bus.hopper_pulse, 0);
        check("reset fault", bus.fault, 0);
        check("reset sold_out", bus.sold_out, 4'b0000);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].vend, vecs[i].sel, vecs[i].chg, vecs[i].k, 0, 1'b1, vecs[i]);
        end

        // Drain slot 0 (7 left), then a vend with 10 rs change refunds 5 coins.
        for (int i = 0; i < 7; i++) run_txn("drain", 1'b1, 2'd0, 2'd0, 2, 0, 1'b0, none_row);
        check("drained sold_out", bus.sold_out, 4'b0001);
        run_txn("soldout_refund", 1'b1, 2'd0, 2'd2, 2, 0, 1'b0, none_row);

        // Restock held with a request: request served, reload on first free IDLE cycle.
        bus.restock = 1'b1;
        run_txn("restock_hold", 1'b1, 2'd0, 2'd0, 2, 0, 1'b0, none_row);
        tick();
        bus.restock = 1'b0;
        for (int i = 0; i < NS; i++) m_stock[i] = INIT;
        check("restock_after sold_out", bus.sold_out, 4'b0000);

        // Change-only request with a vend injected while busy (dropped).
        run_txn("drop_while_busy", 1'b0, 2'd0, 2'd1, 0, 3, 1'b0, none_row);

        // Randomized transactions against the model.
        for (int t = 0; t < 40; t++) begin
            r_v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            r_s = ($urandom_range(0, 9) < 7) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            r_c = 2'($urandom_range(0, 3));
            r_k = $urandom_range(1, 12);
            run_txn("rand", r_v[0], r_s, r_c, r_k, 0, 1'b0, none_row);
            if (t % 12 == 11) do_restock();
        end

        // Motor timeout: fault set, refund, later vends refused.
        do_restock();
        run_txn("timeout", 1'b1, 2'd1, 2'd0, 1000, 0, 1'b0, none_row);
        run_txn("after_fault", 1'b1, 2'd2, 2'd0, 2, 0, 1'b0, none_row);

        // Reset during payout aborts at once and reloads everything.
        bus.change_req = 2'b10;
        tick();
        bus.change_req = 2'b00;
        r_n = 0;
        while (!bus.hopper_pulse && r_n < 20) begin
            tick();
            r_n++;
        end
        check("pre_rst hopper", bus.hopper_pulse, 1);
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid hopper", bus.hopper_pulse, 0);
        check("rst_mid busy", bus.busy, 0);
        check("rst_mid motor_en", bus.motor_en, 4'b0000);
        check("rst_mid fault", bus.fault, 0);
        check("rst_mid sold_out", bus.sold_out, 4'b0000);
        rst = 1'b0;
        model_reset();
        tick();
        run_txn("post_rst_vend", 1'b1, 2'd1, 2'd0, 3, 0, 1'b0, none_row);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vm_dispense_ctrl
`default_nettype wire

// File: doc/vm_dispense_ctrl.md
# vm_dispense_ctrl

Dispense and payout sequencer behind the coin-acceptor FSM of the vending machine. It accepts "paid" and "change owed" events from the coin FSM and arbitrates a per-slot stock inventory. It drives the product motors with a completion/timeout handshake and pays change or refunds as 5 rs coin pulses to a hopper. Price is fixed at 15 rs (three 5 rs coins).

## Interface
- NUM_SLOTS, 4: number of product slots (2..4).
- STOCK_W, 4: width of each slot stock counter.
- INIT_STOCK, 8: stock loaded at reset and on restock (must fit STOCK_W).
- MOTOR_TIMEOUT, 255: max cycles to wait for motor_done.
- PULSE_LEN, 4: hopper pulse high time and inter-pulse low time, in cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- vend_req  in  1  one-cycle pulse: 15 rs paid, vend slot sel.
- change_req  in  2  change owed with this event: 00 none, 01 5 rs, 10 10 rs, 11 treated as 00.
- sel  in  2  slot index, sampled with vend_req.
- restock  in  1  level: reload all stock counters to INIT_STOCK.
- motor_done  in  1  product-drop sensor, level.
- busy  out  1  high whenever state is not IDLE; upstream holds requests low while busy.
- motor_en  out  NUM_SLOTS  one-hot motor drive.
- hopper_pulse  out  1  each high pulse ejects one 5 rs coin.
- sold_out  out  NUM_SLOTS  bit i high when stock[i]==0.
- fault  out  1  sticky motor-timeout flag.

## Operation
- States: IDLE, DISPENSE, PAYOUT_HI, PAYOUT_LO.
- A request event is vend_req=1 or change_req in {01,10}. Events are sampled only in IDLE. Events arriving while busy are dropped with no other effect.
- Event capture in IDLE:
  - coins = change_req code (0, 1 or 2) as a 3-bit count.
  - Vend with sel < NUM_SLOTS, stock[sel] != 0 and fault==0: latch sel, go to DISPENSE.
  - Vend otherwise (sold out, out of range, or fault set): refund. coins += 3, go to PAYOUT_HI.
  - Change only: go to PAYOUT_HI.
- DISPENSE:
  - motor_en[sel]=1 and the timeout counter runs.
  - motor_done=1: decrement stock[sel], clear motor_en. Go to PAYOUT_HI if coins>0, else IDLE.
  - Timeout reached without motor_done: set fault, stock unchanged, coins += 3, go to PAYOUT_HI.
- PAYOUT_HI: hopper_pulse=1 for PULSE_LEN cycles, then coins-=1 and go to PAYOUT_LO.
- PAYOUT_LO: hopper_pulse=0 for PULSE_LEN cycles, then go to PAYOUT_HI if coins>0, else IDLE.
- Maximum coins is 5 (10 rs change plus refund). The count never wraps.
- Restock applies only in IDLE cycles with no request event. A request in the same cycle wins; restock must be held.
- Stock never decrements below 0. sold_out is combinational from the counters.
- fault clears only on rst.

## Timing
- Reset values:
  - state IDLE, busy 0, motor_en 0, hopper_pulse 0, fault 0.
  - coins 0, all stock = INIT_STOCK, sold_out 0.
- Request sampled at edge N: busy and motor_en (or hopper_pulse) are high from cycle N+1.
- motor_done first sampled high at edge M: motor_en is low at M+1 and stock is decremented at M+1.
- Timeout fires when motor_en has been high MOTOR_TIMEOUT cycles. motor_done in that same cycle counts as success.
- Each coin takes 2*PULSE_LEN cycles. Total payout is 2*PULSE_LEN*coins cycles.
- busy falls the cycle after the final low phase or motor completion. A new request is accepted in that first IDLE cycle.
- rst mid-operation aborts immediately: motors and hopper go low next cycle, and owed coins are lost.

## Structure
- Package vm_pkg:
  - state enum.
  - coin code constants (COIN_NONE=00, COIN_5=01, COIN_10=10).
  - PRICE_COINS=3.
  - default parameter values.
- Sub-module vm_hopper_pulser:
  - Takes a 3-bit coin count load plus start.
  - Owns PAYOUT_HI/LO timing and reports done.
  - The main FSM waits in a single PAYOUT state while it runs.

## Test plan
- Reset, then vend_req sel=2, change 00, motor_done 5 cycles later: motor_en=0100 for ~5 cycles, stock[2] 8->7, no hopper pulses, busy low after.
- Vend sel=1, change 10: after motor_done, two hopper pulses of 4 high / 4 low, busy low 16 cycles after motor_en drops.
- Drain slot 0 with 8 vends, then vend slot 0 again: sold_out[0]=1, no motor_en, 3 hopper pulses (refund).
- Vend with motor_done never asserted: motor_en high exactly 255 cycles, fault=1, 3 pulses. A following vend is refunded without motor drive.
- change_req=01 with vend_req=0, then a vend_req pulse while busy: 1 pulse only, second request dropped, stock unchanged.
- restock held together with a request in IDLE: request serviced first, stock reloads to 8 on the first free IDLE cycle. rst during PAYOUT: hopper_pulse low next cycle, all counters at INIT_STOCK.
